alu_exec: RTL
=============

# alu_exec

Parametrised execute-stage ALU for the MIPS datapath. It merges ALU-control decode (ALUOp + funct) with a registered ALU and an iterative multiply/divide unit that owns the HI/LO registers. Single-cycle ops return one edge after issue. MULT/DIV run over WIDTH cycles behind a valid/ready handshake, so the pipeline stalls on `ready`.

## Interface

Parameters:
- WIDTH, 32, operand/result width (≥4, even)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- valid  in  1  issue request; accepted at an edge where valid && ready
- ready  out  1  high when idle (no MULT/DIV in flight)
- alu_op  in  2  00 add, 01 sub, 10 decode funct, 11 illegal
- funct  in  6  R-type funct field, used when alu_op=10
- a  in  WIDTH  operand A (rs; dividend / multiplicand)
- b  in  WIDTH  operand B (rt; divisor / multiplier)
- result  out  WIDTH  registered result, valid while res_valid
- res_valid  out  1  one-cycle completion pulse
- err  out  1  illegal op or divide-by-zero; qualified by res_valid
- ovf  out  1  signed overflow (ADD/SUB, and alu_op 00/01); qualified by res_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation

- Decoded funct values under alu_op=10:
  - ADD 100000, ADDU 100001, SUB 100010, SUBU 100011
  - AND 100100, OR 100101, XOR 100110, NOR 100111
  - SLT 101010, SLTU 101011
  - MFHI 010000, MFLO 010010
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
- alu_op 00/01 behave as ADD/SUB, including ovf.
- Illegal op (alu_op=11 or unlisted funct): result=0, err=1, ovf=0, hi/lo unchanged.
- ADD/SUB: result wraps mod 2^WIDTH; ovf=1 on signed overflow. The U variants never set ovf.
- SLT/SLTU: result is 1 or 0, zero-extended.
- MFHI/MFLO: result is the current hi/lo.
- MULT/MULTU: full 2·WIDTH product; hi gets the upper half, lo the lower half. Signed MULT uses magnitudes, then applies the sign correction.
- DIV/DIVU: quotient to lo, remainder to hi.
  - Signed DIV truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative ÷ −1 gives lo=most-negative, hi=0, err=0.
- Divide by zero (b=0): completes like a single-cycle op with err=1; hi/lo unchanged; no busy period.
- On MULT/DIV completion, result=lo.
- State machine:
  - IDLE: ready=1. Single-cycle ops complete here. MULT* goes to MUL, DIV* with b≠0 goes to DIV; operands are latched and signs recorded.
  - MUL / DIV: ready=0. One shift-add or restoring-subtract step per edge, with an iteration counter running 0..WIDTH−1.
  - Last iteration: write hi, lo, result; pulse res_valid; return to IDLE.
- valid while ready=0 is ignored, not queued. The source must hold the request until it is accepted.

## Timing

- Reset (async, immediate): state=IDLE, ready=1, result=0, res_valid=0, err=0, ovf=0, hi=0, lo=0, counter=0.
  - Reset mid MULT/DIV aborts the op; no res_valid is ever produced for it.
- Accept edge E0:
  - Single-cycle op: result/err/ovf registered at E0; res_valid=1 for the cycle after E0.
  - MULT/DIV: ready falls after E0; iterations run at E1..E_WIDTH.
- At E_WIDTH (MULT/DIV): hi/lo/result registered, res_valid=1, ready=1.
  - A new request may be accepted at E_WIDTH+1.
  - Latency is WIDTH edges after accept.
- Back-to-back single-cycle ops are accepted every edge; res_valid stays high continuously.
- MFHI issued in the result cycle of a MULT sees the new hi, since hi was written at E_WIDTH.
- res_valid is a single-cycle pulse unless a new op completes on the next edge.
- err and ovf are don't-care when res_valid=0; they are driven to 0 on the idle-to-busy edge.

## Test plan

- Reset and abort: issue DIV 100/7, drop rst_n after 5 cycles. Required: all outputs 0 and ready=1 immediately; no res_valid after release; hi=lo=0.
- Add/sub and flags (WIDTH=32):
  - ADD 0x7FFFFFFF+1 → result 0x80000000, ovf=1, one edge after accept.
  - ADDU same operands → ovf=0.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU → 0.
- Multiply:
  - MULT 0xFFFFFFFD×7 → res_valid exactly 32 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=lo.
  - MULTU same → hi=6, lo=0xFFFFFFEB.
  - ready=0 throughout.
- Divide:
  - DIV −7÷2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7÷0 → err=1 one edge after accept, hi/lo unchanged, ready never drops.
  - DIV 0x80000000÷0xFFFFFFFF → lo=0x80000000, hi=0.
- Handshake:
  - Hold valid with ADD during a MULT → ADD accepted only at E33, result after E33.
  - MFLO issued in the MULT result cycle returns the new lo.
  - Five consecutive single-cycle ops → five consecutive res_valid cycles.
- Illegal: funct 111111 with alu_op=10, and alu_op=11 → err=1, result=0, hi/lo unchanged.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with funct decode, registered results and an
// iterative multiply/divide unit owning HI/LO.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             err,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod_s;
  logic [WIDTH-1:0] opd, ma, mb, sum, dif, sc_res, q_s, r_s, fin_hi, fin_lo;
  logic [WIDTH:0] add_hi, sh, df;
  logic [5:0] f;
  logic sc_err, sc_ovf, go_mul, go_div, sgn, neg_q, neg_r, last;
  assign ready = state == IDLE;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    f = alu_op == 2'b10 ? funct : alu_op == 2'b00 ? 6'b100000 : alu_op == 2'b01 ? 6'b100010 : 6'b111111;
    sum = a + b;
    dif = a - b;
    sc_res = '0;
    sc_err = 1'b0;
    sc_ovf = 1'b0;
    go_mul = 1'b0;
    go_div = 1'b0;
    sgn = ~f[0];
    case (f)
      6'b100000: begin
        sc_res = sum;
        sc_ovf = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      6'b100001: sc_res = sum;
      6'b100010: begin
        sc_res = dif;
        sc_ovf = a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
      end
      6'b100011: sc_res = dif;
      6'b100100: sc_res = a & b;
      6'b100101: sc_res = a | b;
      6'b100110: sc_res = a ^ b;
      6'b100111: sc_res = ~(a | b);
      6'b101010: sc_res = WIDTH'($signed(a) < $signed(b));
      6'b101011: sc_res = WIDTH'(a < b);
      6'b010000: sc_res = hi;
      6'b010010: sc_res = lo;
      6'b011000, 6'b011001: go_mul = 1'b1;
      6'b011010, 6'b011011: begin
        go_div = |b;
        sc_err = ~|b;
      end
      default: sc_err = 1'b1;
    endcase
    ma = sgn && a[WIDTH-1] ? -a : a;
    mb = sgn && b[WIDTH-1] ? -b : b;
  end
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_hi = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    df = sh - {1'b0, opd};
    acc_nxt = state == DIV ? {df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0], acc[WIDTH-2:0], ~df[WIDTH]}
                           : {add_hi, acc[WIDTH-1:1]};
    prod_s = neg_q ? -acc_nxt : acc_nxt;
    q_s = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    r_s = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    fin_hi = state == DIV ? r_s : prod_s[2*WIDTH-1:WIDTH];
    fin_lo = state == DIV ? q_s : prod_s[WIDTH-1:0];
    state_nxt = state == IDLE ? (valid && go_mul ? MUL : valid && go_div ? DIV : IDLE) : last ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      opd <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
      res_valid <= 1'b0;
      err <= 1'b0;
      ovf <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      res_valid <= valid && !(go_mul || go_div);
      if (valid && (go_mul || go_div)) begin
        acc <= {{WIDTH{1'b0}}, go_mul ? mb : ma};
        opd <= go_mul ? ma : mb;
        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= sgn && a[WIDTH-1];
        err <= 1'b0;
        ovf <= 1'b0;
      end else if (valid) begin
        result <= sc_res;
        err <= sc_err;
        ovf <= sc_ovf;
      end
    end else begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      res_valid <= last;
      if (last) begin
        hi <= fin_hi;
        lo <= fin_lo;
        result <= fin_lo;
      end
    end
  end
endmodule
